// File: rtl/shifter_pkg.sv
// Shared types and helpers for the shift sequencer.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ASR  = 3'd6
    } shift_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } seq_state_t;

    // Amount width that can express counts up to 2*width-1.
    function automatic int amt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    // True for op codes that move bits one position per step.
    function automatic logic is_step_op(input logic [2:0] op);
        return (op >= 3'd2) && (op <= 3'd6);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of the universal shifter.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] y_i,
    input  logic [2:0]       op_i,
    input  logic             data_l,
    input  logic             data_r,
    output logic [WIDTH-1:0] y_o,
    output logic             out_o
);

    // One step of the selected shift/rotate; non-stepping ops pass Y through.
    always_comb begin
        y_o   = y_i;
        out_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                y_o   = {y_i[WIDTH-2:0], data_r};
                out_o = y_i[WIDTH-1];
            end
            OP_SHR: begin
                y_o   = {data_l, y_i[WIDTH-1:1]};
                out_o = y_i[0];
            end
            OP_ROL: begin
                y_o   = {y_i[WIDTH-2:0], y_i[WIDTH-1]};
                out_o = y_i[WIDTH-1];
            end
            OP_ROR: begin
                y_o   = {y_i[0], y_i[WIDTH-1:1]};
                out_o = y_i[0];
            end
            OP_ASR: begin
                y_o   = {y_i[WIDTH-1], y_i[WIDTH-1:1]};
                out_o = y_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step universal shift register with start/busy/done handshake.
// The first step happens on the accept edge; remaining steps run in SHIFT.
module shift_sequencer
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = amt_width(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start_i,
    input  logic [2:0]       Op_i,
    input  logic [AMT_W-1:0] Amt_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_L,
    input  logic             data_R,
    output logic [WIDTH-1:0] Y_o,
    output logic             Sout_o,
    output logic             Busy_o,
    output logic             Done_o
);

    seq_state_t       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       step_op;
    logic [WIDTH-1:0] step_y;
    logic             step_out;

    // The shared step unit sees the live op when idle and the latched op while shifting.
    always_comb begin
        step_op = (state_q == ST_IDLE) ? Op_i : op_q;
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .y_i    (y_q),
        .op_i   (step_op),
        .data_l (data_L),
        .data_r (data_R),
        .y_o    (step_y),
        .out_o  (step_out)
    );

    // Next-state logic: accept in IDLE, one step per edge in SHIFT.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        y_d     = y_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start_i) begin
                    op_d = Op_i;
                    if (Op_i == OP_LOAD) begin
                        y_d    = data_i;
                        done_d = 1'b1;
                    end else if (is_step_op(Op_i) && (Amt_i != '0)) begin
                        y_d    = step_y;
                        sout_d = step_out;
                        if (Amt_i >= AMT_W'(2)) begin
                            state_d = ST_SHIFT;
                            busy_d  = 1'b1;
                            rem_d   = Amt_i - AMT_W'(1);
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        // HOLD, reserved and zero-count shifts complete without touching Y.
                        done_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                y_d    = step_y;
                sout_d = step_out;
                rem_d  = rem_q - AMT_W'(1);
                if (rem_q == AMT_W'(1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation silently.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rem_q   <= '0;
            y_q     <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            y_q     <= y_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Y_o    = y_q;
    assign Sout_o = sout_q;
    assign Busy_o = busy_q;
    assign Done_o = done_q;

endmodule
